// File: rtl/alu_pkg.sv
// Shared ALU function codes plus the op and state encodings of the sequential mul/div unit.
package alu_pkg;

  localparam logic [5:0] FUN_ADD = 6'b000000;
  localparam logic [5:0] FUN_SUB = 6'b000001;
  localparam logic [5:0] FUN_AND = 6'b011000;
  localparam logic [5:0] FUN_OR  = 6'b011110;
  localparam logic [5:0] FUN_XOR = 6'b010110;
  localparam logic [5:0] FUN_NOR = 6'b010001;
  localparam logic [5:0] FUN_A   = 6'b011010;
  localparam logic [5:0] FUN_SLL = 6'b100000;
  localparam logic [5:0] FUN_SRL = 6'b100001;
  localparam logic [5:0] FUN_SRA = 6'b100011;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } muldivOp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } muldivState_e;

  function automatic logic opIsDiv(input muldivOp_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic opIsSigned(input muldivOp_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Borrowed-ALU port: the mul/div unit requests the shared ALU and uses it only on granted cycles.
interface alu_muldiv_seq_if #(parameter int WIDTH = 32);

  logic             oAluReq;
  logic             iAluGnt;
  logic [WIDTH-1:0] oAluA;
  logic [WIDTH-1:0] oAluB;
  logic [5:0]       oAluFun;
  logic             oAluSign;
  logic [WIDTH-1:0] iAluS;
  logic             iAluV;

  modport master (
    output oAluReq, oAluA, oAluB, oAluFun, oAluSign,
    input  iAluGnt, iAluS, iAluV
  );

  modport slave (
    input  oAluReq, oAluA, oAluB, oAluFun, oAluSign,
    output iAluGnt, iAluS, iAluV
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement: either a full double-width negate or independent half-width negates.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] val,
  input  logic               neg64,
  input  logic               negHi,
  input  logic               negLo,
  output logic [2*WIDTH-1:0] res
);

  always_comb begin
    res = val;
    if (neg64) begin
      res = -val;
    end else begin
      if (negHi) res[2*WIDTH-1:WIDTH] = -val[2*WIDTH-1:WIDTH];
      if (negLo) res[WIDTH-1:0]       = -val[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU: shift-add multiply and restoring divide on magnitudes,
// borrowing the shared ALU for every add/subtract step.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oDivZero,
  alu_muldiv_seq_if.master alu
);

  localparam int CNT_W = $clog2(ITERS);

  muldivState_e state, stateNxt;
  muldivOp_e    op;
  logic [WIDTH-1:0] opA, opB, magB;
  logic [WIDTH-1:0] hi, lo;          // product halves, or remainder/quotient
  logic [CNT_W-1:0] cnt;
  logic             negLo, negHi;    // negate quotient/product, negate remainder
  logic             isDivOp, signedOp, divByZero, lastIter;

  logic [2*WIDTH-1:0] fixIn, fixOut;
  logic               fixNeg64, fixNegHi, fixNegLo;

  logic             aluReq;
  logic [WIDTH-1:0] aluA, aluB;
  logic [5:0]       aluFun;

  assign isDivOp   = opIsDiv(op);
  assign signedOp  = opIsSigned(op);
  assign divByZero = isDivOp && (opB == '0);
  assign lastIter  = (cnt == CNT_W'(ITERS - 1));

  // PREP takes magnitudes of the latched operands; FIX applies the recorded sign corrections.
  always_comb begin
    fixIn    = {hi, lo};
    fixNeg64 = 1'b0;
    fixNegHi = 1'b0;
    fixNegLo = 1'b0;
    if (state == ST_PREP) begin
      fixIn    = {opA, opB};
      fixNegHi = signedOp & opA[WIDTH-1];
      fixNegLo = signedOp & opB[WIDTH-1];
    end else if (isDivOp) begin
      fixNegHi = negHi;
      fixNegLo = negLo;
    end else begin
      fixNeg64 = negLo;
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) uSignFix (
    .val  (fixIn),
    .neg64(fixNeg64),
    .negHi(fixNegHi),
    .negLo(fixNegLo),
    .res  (fixOut)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    aluReq   = 1'b0;
    aluA     = '0;
    aluB     = '0;
    aluFun   = FUN_ADD;
    unique case (state)
      ST_IDLE: if (iStart) stateNxt = ST_PREP;
      ST_PREP: stateNxt = divByZero ? ST_DONE : ST_ITER;
      ST_ITER: begin
        aluReq = 1'b1;
        aluB   = magB;
        if (isDivOp) begin
          aluFun = FUN_SUB;
          aluA   = {hi[WIDTH-2:0], lo[WIDTH-1]};
        end else begin
          aluA   = hi;
        end
        if (alu.iAluGnt && lastIter) stateNxt = ST_FIX;
      end
      ST_FIX:  stateNxt = ST_DONE;
      ST_DONE: stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  assign oBusy        = (state != ST_IDLE);
  assign oDone        = (state == ST_DONE);
  assign alu.oAluReq  = aluReq;
  assign alu.oAluA    = aluA;
  assign alu.oAluB    = aluB;
  assign alu.oAluFun  = aluFun;
  assign alu.oAluSign = 1'b0;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      op       <= OP_MULTU;
      opA      <= '0;
      opB      <= '0;
      magB     <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
      oHi      <= '0;
      oLo      <= '0;
      oDivZero <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (iStart) begin
          op  <= muldivOp_e'(iOp);
          opA <= iA;
          opB <= iB;
        end
        ST_PREP: begin
          cnt   <= '0;
          hi    <= '0;
          lo    <= fixOut[2*WIDTH-1:WIDTH];
          magB  <= fixOut[WIDTH-1:0];
          negLo <= fixNegHi ^ fixNegLo;
          negHi <= fixNegHi;
          if (divByZero) begin
            oHi      <= opA;
            oLo      <= '1;
            oDivZero <= 1'b1;
          end
        end
        ST_ITER: if (alu.iAluGnt) begin
          cnt <= cnt + 1'b1;
          if (isDivOp) begin
            // Restoring step: keep the difference when the shifted remainder covers |B|.
            if (hi[WIDTH-1] | ~alu.iAluV) begin
              hi <= alu.iAluS;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= aluA;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else if (lo[0]) begin
            hi <= {alu.iAluV, alu.iAluS[WIDTH-1:1]};
            lo <= {alu.iAluS[0], lo[WIDTH-1:1]};
          end else begin
            hi <= {1'b0, hi[WIDTH-1:1]};
            lo <= {hi[0], lo[WIDTH-1:1]};
          end
        end
        ST_FIX: begin
          oHi      <= fixOut[2*WIDTH-1:WIDTH];
          oLo      <= fixOut[WIDTH-1:0];
          oDivZero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
